// File: rtl/flood_pkg.sv
// flood_pkg: shared sizes, colour/board/mask types, FSM state enum and size clamp.
// Also imported by the board generator for color_t.
package flood_pkg;
    localparam int MAX_SIZE = 26;
    localparam int COLOR_W  = 3;
    localparam int MOVE_W   = 8;
    localparam int CNT_W    = 10;
    typedef logic [COLOR_W-1:0] color_t;
    typedef color_t [MAX_SIZE-1:0][MAX_SIZE-1:0] board_t;
    typedef logic [MAX_SIZE-1:0][MAX_SIZE-1:0] mask_t;
    typedef logic [4:0] idx_t;
    typedef enum logic [1:0] {IDLE, PAINT, SWEEP, CHECK} state_t;
    // 0 or 1 becomes 1, anything above MAX_SIZE becomes MAX_SIZE
    function automatic idx_t clamp_size(idx_t s);
        return (s < 5'd2) ? 5'd1 : (s > 5'(MAX_SIZE)) ? 5'(MAX_SIZE) : s;
    endfunction
endpackage

// File: rtl/flood_engine_if.sv
// flood_engine_if: control/board bus between the game controller (master) and flood_engine (slave).
// Master drives LOAD, INITIAL_BOARD, SIZE, MOVE, MOVE_COLOR;
// slave drives BOARD, BUSY, MOVE_DONE, MOVES, WON.
interface flood_engine_if;
    import flood_pkg::*;
    logic                LOAD;
    board_t              INITIAL_BOARD;
    idx_t                SIZE;
    logic                MOVE;
    color_t              MOVE_COLOR;
    board_t              BOARD;
    logic                BUSY;
    logic                MOVE_DONE;
    logic [MOVE_W-1:0]   MOVES;
    logic                WON;
    modport master (
        output LOAD, INITIAL_BOARD, SIZE, MOVE, MOVE_COLOR,
        input  BOARD, BUSY, MOVE_DONE, MOVES, WON
    );
    modport slave (
        input  LOAD, INITIAL_BOARD, SIZE, MOVE, MOVE_COLOR,
        output BOARD, BUSY, MOVE_DONE, MOVES, WON
    );
endinterface

// File: rtl/flood_neighbor_check.sv
// flood_neighbor_check: reports whether any in-range 4-neighbour of (row,col) is flooded.
// Ports: i_flood flood mask, i_row/i_col cell under test, i_size active dimension,
//        o_any high when an up/down/left/right neighbour inside the board is flooded.
module flood_neighbor_check
    import flood_pkg::*;
(
    input  mask_t i_flood,
    input  idx_t  i_row,
    input  idx_t  i_col,
    input  idx_t  i_size,
    output logic  o_any
);
    logic w_up, w_dn, w_lf, w_rt;
    // guards keep edge and corner cells from looking outside the active board
    assign w_up  = (i_row != 5'd0) ? i_flood[i_row - 5'd1][i_col] : 1'b0;
    assign w_dn  = (i_row + 5'd1 < i_size) ? i_flood[i_row + 5'd1][i_col] : 1'b0;
    assign w_lf  = (i_col != 5'd0) ? i_flood[i_row][i_col - 5'd1] : 1'b0;
    assign w_rt  = (i_col + 5'd1 < i_size) ? i_flood[i_row][i_col + 5'd1] : 1'b0;
    assign o_any = w_up | w_dn | w_lf | w_rt;
endmodule

// File: rtl/flood_engine.sv
// flood_engine: Flood-It game state; captures a board, repaints the flooded region on each move
// and regrows it with raster sweeps until a sweep adds nothing.
// Ports: CLOCK, RESET (async, active high), bus (flood_engine_if.slave):
//        LOAD/INITIAL_BOARD/SIZE start a game, MOVE/MOVE_COLOR pick a colour,
//        BOARD/BUSY/MOVE_DONE/MOVES/WON report the live game.
module flood_engine
    import flood_pkg::*;
(
    input  logic          CLOCK,
    input  logic          RESET,
    flood_engine_if.slave bus
);
    state_t             r_state;
    board_t             r_board;
    mask_t              r_flood;
    idx_t               r_size, r_row, r_col;
    logic               r_changed;
    logic [CNT_W-1:0]   r_flood_cnt;
    color_t             r_cur_color;
    logic [MOVE_W-1:0]  r_moves;
    logic               r_won, r_busy, r_move_done, r_by_move;
    logic               w_nbr, w_join, w_last_col, w_last;

    flood_neighbor_check u_nbr (
        .i_flood (r_flood),
        .i_row   (r_row),
        .i_col   (r_col),
        .i_size  (r_size),
        .o_any   (w_nbr)
    );

    assign w_join     = !r_flood[r_row][r_col] && r_board[r_row][r_col] == r_cur_color && w_nbr;
    assign w_last_col = r_col == r_size - 5'd1;
    assign w_last     = w_last_col && r_row == r_size - 5'd1;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_board     <= '0;
            r_flood     <= '0;
            r_size      <= 5'd1;
            r_row       <= '0;
            r_col       <= '0;
            r_changed   <= 1'b0;
            r_flood_cnt <= '0;
            r_cur_color <= '0;
            r_moves     <= '0;
            r_won       <= 1'b0;
            r_busy      <= 1'b0;
            r_move_done <= 1'b0;
            r_by_move   <= 1'b0;
        end else begin
            r_move_done <= 1'b0;
            if (bus.LOAD) begin
                r_board     <= bus.INITIAL_BOARD;
                r_size      <= clamp_size(bus.SIZE);
                r_flood     <= mask_t'(1);  // bit 0 is cell (0,0)
                r_flood_cnt <= CNT_W'(1);
                r_cur_color <= bus.INITIAL_BOARD[0][0];
                r_moves     <= '0;
                r_won       <= 1'b0;
                r_changed   <= 1'b0;
                r_row       <= '0;
                r_col       <= '0;
                r_by_move   <= 1'b0;
                r_busy      <= 1'b1;
                r_state     <= SWEEP;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.MOVE && !r_won) begin
                            if (bus.MOVE_COLOR == r_cur_color) begin
                                r_move_done <= 1'b1;
                            end else begin
                                r_moves     <= (r_moves == '1) ? r_moves : r_moves + 1'b1;
                                r_cur_color <= bus.MOVE_COLOR;
                                r_by_move   <= 1'b1;
                                r_busy      <= 1'b1;
                                r_state     <= PAINT;
                            end
                        end
                    end
                    PAINT: begin
                        // only active cells can ever be flooded, so outside cells stay untouched
                        for (int i = 0; i < MAX_SIZE; i++)
                            for (int j = 0; j < MAX_SIZE; j++)
                                if (r_flood[i][j]) r_board[i][j] <= r_cur_color;
                        r_changed <= 1'b0;
                        r_row     <= '0;
                        r_col     <= '0;
                        r_state   <= SWEEP;
                    end
                    SWEEP: begin
                        if (w_join) begin
                            r_flood[r_row][r_col] <= 1'b1;
                            r_flood_cnt           <= r_flood_cnt + 1'b1;
                            r_changed             <= 1'b1;
                        end
                        r_col <= w_last_col ? 5'd0 : r_col + 5'd1;
                        r_row <= w_last_col ? r_row + 5'd1 : r_row;
                        if (w_last) r_state <= CHECK;
                    end
                    CHECK: begin
                        if (r_changed) begin
                            r_changed <= 1'b0;
                            r_row     <= '0;
                            r_col     <= '0;
                            r_state   <= SWEEP;
                        end else begin
                            r_won       <= r_flood_cnt == CNT_W'(r_size) * CNT_W'(r_size);
                            r_move_done <= r_by_move;
                            r_busy      <= 1'b0;
                            r_state     <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.BOARD     = r_board;
    assign bus.BUSY      = r_busy;
    assign bus.MOVE_DONE = r_move_done;
    assign bus.MOVES     = r_moves;
    assign bus.WON       = r_won;
endmodule

// File: tb/tb_flood_engine.sv
// tb_flood_engine: directed self-checking bench for flood_engine.
module tb_flood_engine;
    import flood_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    flood_engine_if bus();
    flood_engine dut (.CLOCK(clk), .RESET(rst), .bus(bus.slave));
    always #5 clk = ~clk;

    function automatic int first_diff(board_t a, board_t e);
        for (int r = 0; r < MAX_SIZE; r++)
            for (int c = 0; c < MAX_SIZE; c++)
                if (a[r][c] !== e[r][c]) return r * MAX_SIZE + c;
        return 0;
    endfunction

    function automatic board_t fill(color_t v);
        board_t b;
        for (int r = 0; r < MAX_SIZE; r++)
            for (int c = 0; c < MAX_SIZE; c++) b[r][c] = v;
        return b;
    endfunction

    task automatic do_load(input board_t bd, input idx_t sz);
        @(negedge clk);
        bus.INITIAL_BOARD = bd;
        bus.SIZE = sz;
        bus.LOAD = 1'b1;
        @(negedge clk);
        bus.LOAD = 1'b0;
    endtask

    task automatic do_move(input color_t c);
        @(negedge clk);
        bus.MOVE_COLOR = c;
        bus.MOVE = 1'b1;
        @(negedge clk);
        bus.MOVE = 1'b0;
    endtask

    task automatic wait_idle(output int n, output logic seen);
        n = 0;
        seen = bus.MOVE_DONE;
        while (bus.BUSY && n < 5000) begin
            @(negedge clk);
            n++;
            seen = seen | bus.MOVE_DONE;
        end
        if (bus.BUSY) begin
            tests++; fails++;
            $display("FAIL wait_idle timeout: BUSY got 1 expected 0 after %0d cycles", n);
        end
    endtask

    function automatic board_t board3();
        board_t b;
        b = fill(3'd6);
        b[0][0] = 3'd0; b[0][1] = 3'd1; b[0][2] = 3'd1;
        b[1][0] = 3'd1; b[1][1] = 3'd1; b[1][2] = 3'd2;
        b[2][0] = 3'd2; b[2][1] = 3'd2; b[2][2] = 3'd2;
        return b;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        tests++; if (bus.BUSY !== 1'b0) begin fails++; $display("FAIL reset busy: got %0b expected 0", bus.BUSY); end
        tests++; if (bus.MOVES !== 8'd0) begin fails++; $display("FAIL reset moves: got %0d expected 0", bus.MOVES); end
        tests++; if (bus.WON !== 1'b0) begin fails++; $display("FAIL reset won: got %0b expected 0", bus.WON); end
        tests++; if (bus.MOVE_DONE !== 1'b0) begin fails++; $display("FAIL reset move_done: got %0b expected 0", bus.MOVE_DONE); end
        tests++; if (bus.BOARD !== '0) begin fails++; $display("FAIL reset board: cell %0d nonzero", first_diff(bus.BOARD, '0)); end
        rst = 1'b0;
    endtask

    task automatic test_uniform();
        board_t b; int n; logic seen; int d;
        b = fill(3'd7);
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) b[r][c] = 3'd2;
        do_load(b, 5'd4);
        wait_idle(n, seen);
        // first sweep floods everything, second sweep confirms no change
        tests++; if (n !== 34) begin fails++; $display("FAIL uniform latency: got %0d expected 34", n); end
        tests++; if (bus.WON !== 1'b1) begin fails++; $display("FAIL uniform won: got %0b expected 1", bus.WON); end
        tests++; if (bus.MOVES !== 8'd0) begin fails++; $display("FAIL uniform moves: got %0d expected 0", bus.MOVES); end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL uniform move_done: got %0b expected 0", seen); end
        tests++; if (bus.BOARD !== b) begin fails++; d = first_diff(bus.BOARD, b);
            $display("FAIL uniform board: cell %0d got %0d expected %0d", d, bus.BOARD[d/26][d%26], b[d/26][d%26]); end
    endtask

    task automatic test_moves();
        board_t b, e; int n; logic seen; int d;
        b = board3();
        do_load(b, 5'd3);
        wait_idle(n, seen);
        tests++; if (n !== 10) begin fails++; $display("FAIL load3 latency: got %0d expected 10", n); end
        tests++; if (bus.WON !== 1'b0) begin fails++; $display("FAIL load3 won: got %0b expected 0", bus.WON); end
        do_move(3'd1);
        wait_idle(n, seen);
        e = b; e[0][0] = 3'd1;
        tests++; if (n !== 21) begin fails++; $display("FAIL move1 latency: got %0d expected 21", n); end
        tests++; if (seen !== 1'b1) begin fails++; $display("FAIL move1 move_done: got %0b expected 1", seen); end
        tests++; if (bus.MOVES !== 8'd1) begin fails++; $display("FAIL move1 moves: got %0d expected 1", bus.MOVES); end
        tests++; if (bus.WON !== 1'b0) begin fails++; $display("FAIL move1 won: got %0b expected 0", bus.WON); end
        tests++; if (bus.BOARD !== e) begin fails++; d = first_diff(bus.BOARD, e);
            $display("FAIL move1 board: cell %0d got %0d expected %0d", d, bus.BOARD[d/26][d%26], e[d/26][d%26]); end
        do_move(3'd2);
        wait_idle(n, seen);
        for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) e[r][c] = 3'd2;
        tests++; if (n !== 21) begin fails++; $display("FAIL move2 latency: got %0d expected 21", n); end
        tests++; if (bus.MOVES !== 8'd2) begin fails++; $display("FAIL move2 moves: got %0d expected 2", bus.MOVES); end
        tests++; if (bus.WON !== 1'b1) begin fails++; $display("FAIL move2 won: got %0b expected 1", bus.WON); end
        tests++; if (bus.BOARD !== e) begin fails++; d = first_diff(bus.BOARD, e);
            $display("FAIL move2 board: cell %0d got %0d expected %0d", d, bus.BOARD[d/26][d%26], e[d/26][d%26]); end
        do_move(3'd3);
        wait_idle(n, seen);
        tests++; if (n !== 0 || seen !== 1'b0) begin fails++; $display("FAIL move_after_won: busy cycles %0d done %0b expected 0 0", n, seen); end
        tests++; if (bus.MOVES !== 8'd2) begin fails++; $display("FAIL move_after_won moves: got %0d expected 2", bus.MOVES); end
    endtask

    task automatic test_same_color();
        int n; logic seen;
        do_load(board3(), 5'd3);
        wait_idle(n, seen);
        do_move(3'd0);
        wait_idle(n, seen);
        tests++; if (n !== 0) begin fails++; $display("FAIL same_color busy: got %0d cycles expected 0", n); end
        tests++; if (seen !== 1'b1) begin fails++; $display("FAIL same_color move_done: got %0b expected 1", seen); end
        tests++; if (bus.MOVES !== 8'd0) begin fails++; $display("FAIL same_color moves: got %0d expected 0", bus.MOVES); end
    endtask

    task automatic test_serpentine();
        board_t b, e; int n; logic seen; int d;
        b = fill(3'd7);
        for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) b[r][c] = 3'd0;
        for (int r = 1; r < 5; r++) begin b[r][0] = 3'd1; b[r][4] = 3'd1; end
        for (int r = 0; r < 4; r++) b[r][2] = 3'd1;
        b[4][1] = 3'd1; b[4][2] = 3'd1; b[0][3] = 3'd1; b[0][4] = 3'd1;
        b[0][0] = 3'd3;
        do_load(b, 5'd5);
        wait_idle(n, seen);
        tests++; if (n !== 26) begin fails++; $display("FAIL serp load latency: got %0d expected 26", n); end
        do_move(3'd1);
        wait_idle(n, seen);
        // the climb up column 2 gains one cell per sweep: k = 6
        tests++; if (n !== 157) begin fails++; $display("FAIL serp move latency: got %0d expected 157", n); end
        tests++; if (bus.WON !== 1'b0) begin fails++; $display("FAIL serp won: got %0b expected 0", bus.WON); end
        do_move(3'd2);
        wait_idle(n, seen);
        e = b; e[0][0] = 3'd1;
        for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) if (e[r][c] == 3'd1) e[r][c] = 3'd2;
        tests++; if (n !== 27) begin fails++; $display("FAIL serp repaint latency: got %0d expected 27", n); end
        tests++; if (bus.BOARD !== e) begin fails++; d = first_diff(bus.BOARD, e);
            $display("FAIL serp mask board: cell %0d got %0d expected %0d", d, bus.BOARD[d/26][d%26], e[d/26][d%26]); end
        do_move(3'd0);
        wait_idle(n, seen);
        for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) e[r][c] = 3'd0;
        tests++; if (n !== 53) begin fails++; $display("FAIL serp final latency: got %0d expected 53", n); end
        tests++; if (bus.WON !== 1'b1 || bus.MOVES !== 8'd3) begin fails++; $display("FAIL serp final: won %0b moves %0d expected 1 3", bus.WON, bus.MOVES); end
        tests++; if (bus.BOARD !== e) begin fails++; d = first_diff(bus.BOARD, e);
            $display("FAIL serp final board: cell %0d got %0d expected %0d", d, bus.BOARD[d/26][d%26], e[d/26][d%26]); end
    endtask

    task automatic test_busy_load();
        board_t b; int n; logic seen; logic any_done; int d;
        b = board3();
        do_load(b, 5'd3);
        wait_idle(n, seen);
        do_move(3'd1);
        any_done = bus.MOVE_DONE;
        @(negedge clk); any_done = any_done | bus.MOVE_DONE;
        @(negedge clk); any_done = any_done | bus.MOVE_DONE;
        bus.MOVE_COLOR = 3'd2; bus.MOVE = 1'b1;
        @(negedge clk); any_done = any_done | bus.MOVE_DONE;
        bus.MOVE = 1'b0;
        tests++; if (bus.MOVES !== 8'd1) begin fails++; $display("FAIL busy_move moves: got %0d expected 1", bus.MOVES); end
        do_load(b, 5'd3);
        wait_idle(n, seen);
        any_done = any_done | seen;
        tests++; if (n !== 10) begin fails++; $display("FAIL abort reload latency: got %0d expected 10", n); end
        tests++; if (any_done !== 1'b0) begin fails++; $display("FAIL abort move_done: got %0b expected 0", any_done); end
        tests++; if (bus.MOVES !== 8'd0) begin fails++; $display("FAIL abort moves: got %0d expected 0", bus.MOVES); end
        tests++; if (bus.BOARD !== b) begin fails++; d = first_diff(bus.BOARD, b);
            $display("FAIL abort board: cell %0d got %0d expected %0d", d, bus.BOARD[d/26][d%26], b[d/26][d%26]); end
        @(negedge clk);
        bus.INITIAL_BOARD = b; bus.SIZE = 5'd3; bus.LOAD = 1'b1;
        bus.MOVE_COLOR = 3'd1; bus.MOVE = 1'b1;
        @(negedge clk);
        bus.LOAD = 1'b0; bus.MOVE = 1'b0;
        wait_idle(n, seen);
        tests++; if (n !== 10 || bus.MOVES !== 8'd0 || seen !== 1'b0) begin fails++;
            $display("FAIL load_and_move: latency %0d moves %0d done %0b expected 10 0 0", n, bus.MOVES, seen); end
    endtask

    task automatic test_reset_clamp();
        board_t b; int n; logic seen;
        b = fill(3'd5); b[0][0] = 3'd1;
        do_load(b, 5'd26);
        wait_idle(n, seen);
        tests++; if (n !== 677) begin fails++; $display("FAIL load26 latency: got %0d expected 677", n); end
        do_move(3'd5);
        repeat (10) @(negedge clk);
        tests++; if (bus.BUSY !== 1'b1 || bus.MOVES !== 8'd1) begin fails++; $display("FAIL pre_reset: busy %0b moves %0d expected 1 1", bus.BUSY, bus.MOVES); end
        #2 rst = 1'b1;
        #1;
        tests++; if (bus.BUSY !== 1'b0 || bus.MOVES !== 8'd0 || bus.WON !== 1'b0) begin fails++;
            $display("FAIL async_reset: busy %0b moves %0d won %0b expected 0 0 0", bus.BUSY, bus.MOVES, bus.WON); end
        tests++; if (bus.BOARD !== '0) begin fails++; $display("FAIL async_reset board: cell %0d nonzero", first_diff(bus.BOARD, '0)); end
        @(negedge clk);
        rst = 1'b0;
        b = fill(3'd5); b[0][0] = 3'd4;
        do_load(b, 5'd0);
        wait_idle(n, seen);
        tests++; if (n !== 2 || bus.WON !== 1'b1) begin fails++; $display("FAIL clamp_low: latency %0d won %0b expected 2 1", n, bus.WON); end
        do_load(fill(3'd5), 5'd31);
        wait_idle(n, seen);
        tests++; if (n !== 1354 || bus.WON !== 1'b1) begin fails++; $display("FAIL clamp_high: latency %0d won %0b expected 1354 1", n, bus.WON); end
    endtask

    initial begin
        bus.LOAD = 1'b0;
        bus.MOVE = 1'b0;
        bus.SIZE = '0;
        bus.MOVE_COLOR = '0;
        bus.INITIAL_BOARD = '0;
        test_reset();
        test_uniform();
        test_moves();
        test_same_color();
        test_serpentine();
        test_busy_load();
        test_reset_clamp();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
